// File: rtl/memctl_refill_responder.sv
// memctl_refill_responder
//   Memory-controller stand-in for the cache refill channel. Line-miss
//   requests are queued in arrival order. Each queued entry ages once per
//   cycle. When the head entry is LATENCY cycles old, one refill beat is
//   offered on memctl_refill_*. The beat carries the line id and a data
//   pattern derived from that id.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   miss_req_valid/ready request handshake (ready = queue not full)
//   miss_req_id          line id to refill
//   memctl_refill_valid  beat present (held until memctl_refill_ready)
//   memctl_refill_ready  consumer accepts beat
//   memctl_refill_id     line id of beat (0 when no beat)
//   memctl_refill_data   word k = {C0+k, 16'h0000, id} (0 when no beat)
//   outstanding          entries currently queued, 0..DEPTH
module memctl_refill_responder #(
    parameter int NLINE_W = 5,
    parameter int DATA_W  = 128,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      miss_req_valid,
    output logic                      miss_req_ready,
    input  logic [NLINE_W-1:0]        miss_req_id,
    output logic                      memctl_refill_valid,
    input  logic                      memctl_refill_ready,
    output logic [NLINE_W-1:0]        memctl_refill_id,
    output logic [DATA_W-1:0]         memctl_refill_data,
    output logic [$clog2(DEPTH):0]    outstanding
);

    localparam int          PW    = $clog2(DEPTH);
    localparam int          NWORD = DATA_W / 32;
    localparam logic [7:0]  LAT8  = 8'(LATENCY);

    logic [PW:0]        wr_ptr;
    logic [PW:0]        rd_ptr;
    logic [PW-1:0]      wr_idx;
    logic [PW-1:0]      rd_idx;
    logic [NLINE_W-1:0] id_q  [DEPTH];
    logic [7:0]         age_q [DEPTH];
    logic               full;
    logic               empty;
    logic               head_ready;
    logic               push;
    logic               pop;
    logic [7:0]         head_id8;

    assign wr_idx = wr_ptr[PW-1:0];
    assign rd_idx = rd_ptr[PW-1:0];

    // Extra wrap bit on each pointer distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);

    // Ready ignores a same-cycle pop. A full queue therefore stays
    // not-ready for the cycle in which the head leaves.
    assign miss_req_ready = !full && !rst;
    assign head_ready     = !empty && (age_q[rd_idx] == LAT8);
    assign push           = miss_req_valid && miss_req_ready;
    assign pop            = head_ready && memctl_refill_ready;

    assign outstanding = wr_ptr - rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Ages saturate at LATENCY, so a head held back by ready=0 never wraps.
    // Slots outside the occupied window also age. Their age is unobservable,
    // because the head check is gated by !empty and a push reloads age 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                id_q[i]  <= '0;
                age_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (push && (wr_idx == PW'(i))) begin
                    id_q[i]  <= miss_req_id;
                    age_q[i] <= '0;
                end else if (age_q[i] != LAT8) begin
                    age_q[i] <= age_q[i] + 8'd1;
                end
            end
        end
    end

    assign head_id8 = 8'(id_q[rd_idx]);

    always_comb begin
        memctl_refill_valid = 1'b0;
        memctl_refill_id    = '0;
        memctl_refill_data  = '0;
        if (head_ready) begin
            memctl_refill_valid = 1'b1;
            memctl_refill_id    = id_q[rd_idx];
            for (int unsigned k = 0; k < NWORD; k++) begin
                memctl_refill_data[32*k +: 32] = {8'(32'hC0 + k), 16'h0000, head_id8};
            end
        end
    end

endmodule

// File: tb/tb_memctl_refill_responder.sv
// tb_memctl_refill_responder
//   Scoreboard bench for memctl_refill_responder. Inputs change 1 ns after a
//   rising edge. A monitor samples the outputs on the falling edge.
module tb_memctl_refill_responder;

    localparam int NLINE_W = 5;
    localparam int DATA_W  = 128;
    localparam int DEPTH   = 4;
    localparam int LATENCY = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               miss_req_valid;
    logic               miss_req_ready;
    logic [NLINE_W-1:0] miss_req_id;
    logic               memctl_refill_valid;
    logic               memctl_refill_ready;
    logic [NLINE_W-1:0] memctl_refill_id;
    logic [DATA_W-1:0]  memctl_refill_data;
    logic [2:0]         outstanding;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc    = 0;

    typedef struct {
        logic [NLINE_W-1:0] id;
        int unsigned        acc;
    } sb_t;
    sb_t sb[$];

    memctl_refill_responder #(
        .NLINE_W(NLINE_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .miss_req_valid     (miss_req_valid),
        .miss_req_ready     (miss_req_ready),
        .miss_req_id        (miss_req_id),
        .memctl_refill_valid(memctl_refill_valid),
        .memctl_refill_ready(memctl_refill_ready),
        .memctl_refill_id   (memctl_refill_id),
        .memctl_refill_data (memctl_refill_data),
        .outstanding        (outstanding)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] line_data(input logic [NLINE_W-1:0] id);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int k = 0; k < DATA_W / 32; k++) begin
            d[32*k +: 32] = {8'hC0 + 8'(k), 16'h0000, 3'b000, id};
        end
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Records the expected beat when the request is accepted. The accept
    // edge is the next rising edge, so its cycle number is cyc+1.
    task automatic send(input logic [NLINE_W-1:0] id);
        int unsigned n;
        sb_t e;
        n = 0;
        miss_req_valid = 1'b1;
        miss_req_id    = id;
        while (!miss_req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", 128'(miss_req_ready), 128'(1));
        if (miss_req_ready) begin
            e.id  = id;
            e.acc = cyc + 1;
            sb.push_back(e);
            tick();
        end
        miss_req_valid = 1'b0;
    endtask

    task automatic probe_latency(input logic [NLINE_W-1:0] id, input logic [DATA_W-1:0] exp_data);
        send(id);
        repeat (LATENCY - 1) tick();
        chk("lat_early_valid", 128'(memctl_refill_valid), 128'(0));
        tick();
        chk("lat_valid", 128'(memctl_refill_valid), 128'(1));
        chk("lat_id", 128'(memctl_refill_id), 128'(id));
        chk("lat_data", 128'(memctl_refill_data), 128'(exp_data));
    endtask

    task automatic wait_drain();
        int unsigned n;
        n = 0;
        while ((sb.size() != 0 || outstanding != 0) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_sb", 128'(sb.size()), 128'(0));
        chk("drain_outstanding", 128'(outstanding), 128'(0));
    endtask

    // Monitor: beats are checked against the scoreboard. A stalled beat must
    // hold steady, and id/data must be zero whenever there is no beat.
    initial begin : monitor
        sb_t                e;
        logic               pv;
        logic               pr;
        logic [NLINE_W-1:0] pid;
        logic [DATA_W-1:0]  pdata;
        pv = 1'b0;
        pr = 1'b0;
        pid = '0;
        pdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    chk("hold_valid", 128'(memctl_refill_valid), 128'(1));
                    chk("hold_id", 128'(memctl_refill_id), 128'(pid));
                    chk("hold_data", 128'(memctl_refill_data), 128'(pdata));
                end
                if (!memctl_refill_valid) begin
                    chk("idle_id", 128'(memctl_refill_id), 128'(0));
                    chk("idle_data", 128'(memctl_refill_data), 128'(0));
                end else if (memctl_refill_ready) begin
                    chk("beat_expected", 128'(sb.size() != 0), 128'(1));
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("beat_id", 128'(memctl_refill_id), 128'(e.id));
                        chk("beat_data", 128'(memctl_refill_data), 128'(line_data(e.id)));
                        chk("beat_latency", 128'((cyc - e.acc) >= LATENCY), 128'(1));
                    end
                end
                pv = memctl_refill_valid;
                pr = memctl_refill_ready;
                pid = memctl_refill_id;
                pdata = memctl_refill_data;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst = 1'b1;
        miss_req_valid = 1'b0;
        miss_req_id = '0;
        memctl_refill_ready = 1'b1;
        repeat (3) tick();
        chk("rst_req_ready", 128'(miss_req_ready), 128'(0));
        chk("rst_valid", 128'(memctl_refill_valid), 128'(0));
        chk("rst_id", 128'(memctl_refill_id), 128'(0));
        chk("rst_data", 128'(memctl_refill_data), 128'(0));
        chk("rst_outstanding", 128'(outstanding), 128'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", 128'(miss_req_ready), 128'(1));

        // Single request: exact latency and literal data pattern.
        probe_latency(5'h1D, 128'hC300001D_C200001D_C100001D_C000001D);
        tick();
        chk("single_one_beat", 128'(memctl_refill_valid), 128'(0));
        wait_drain();

        // Fill the queue, refuse a fifth request, then drain back to back.
        memctl_refill_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(NLINE_W'(i));
        miss_req_valid = 1'b1;
        miss_req_id = 5'd5;
        chk("full_req_ready", 128'(miss_req_ready), 128'(0));
        chk("full_outstanding", 128'(outstanding), 128'(4));
        miss_req_valid = 1'b0;
        repeat (10) tick();
        memctl_refill_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("b2b_valid", 128'(memctl_refill_valid), 128'(1));
            chk("b2b_id", 128'(memctl_refill_id), 128'(i));
            tick();
        end
        chk("b2b_done_valid", 128'(memctl_refill_valid), 128'(0));
        chk("b2b_done_outstanding", 128'(outstanding), 128'(0));

        // Long stall: the monitor's hold checks run every cycle.
        memctl_refill_ready = 1'b0;
        send(5'd7);
        repeat (300) tick();
        chk("stall_valid", 128'(memctl_refill_valid), 128'(1));
        chk("stall_id", 128'(memctl_refill_id), 128'(7));
        memctl_refill_ready = 1'b1;
        tick();
        chk("stall_pop_valid", 128'(memctl_refill_valid), 128'(0));
        chk("stall_pop_outstanding", 128'(outstanding), 128'(0));

        // Full queue: head pops while a request waits. No push that cycle.
        memctl_refill_ready = 1'b0;
        for (int i = 8; i <= 11; i++) send(NLINE_W'(i));
        repeat (10) tick();
        chk("fp_outstanding4", 128'(outstanding), 128'(4));
        miss_req_valid = 1'b1;
        miss_req_id = 5'd12;
        memctl_refill_ready = 1'b1;
        chk("fp_req_ready_full", 128'(miss_req_ready), 128'(0));
        tick();
        memctl_refill_ready = 1'b0;
        chk("fp_outstanding3", 128'(outstanding), 128'(3));
        chk("fp_req_ready_after", 128'(miss_req_ready), 128'(1));
        begin
            sb_t e;
            e.id = 5'd12;
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        tick();
        miss_req_valid = 1'b0;
        chk("fp_outstanding4_again", 128'(outstanding), 128'(4));
        memctl_refill_ready = 1'b1;
        wait_drain();

        // Push and pop in the same cycle with two entries queued.
        memctl_refill_ready = 1'b0;
        send(5'd20);
        send(5'd21);
        repeat (10) tick();
        chk("pp_outstanding_pre", 128'(outstanding), 128'(2));
        memctl_refill_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb_t e;
            miss_req_valid = 1'b1;
            miss_req_id = NLINE_W'(22 + i);
            chk("pp_req_ready", 128'(miss_req_ready), 128'(1));
            chk("pp_head_valid", 128'(memctl_refill_valid), 128'(1));
            e.id = NLINE_W'(22 + i);
            e.acc = cyc + 1;
            sb.push_back(e);
            tick();
            chk("pp_outstanding", 128'(outstanding), 128'(2));
        end
        miss_req_valid = 1'b0;
        wait_drain();

        // Random stream with ready held high. The pointers wrap several times.
        for (int i = 0; i < 12; i++) send(NLINE_W'($urandom_range(0, 31)));
        send(5'd3);
        send(5'd3);
        wait_drain();

        // Reset while entries are queued and a beat is being offered.
        memctl_refill_ready = 1'b0;
        send(5'd30);
        send(5'd31);
        send(5'd32);
        repeat (10) tick();
        chk("mr_valid_pre", 128'(memctl_refill_valid), 128'(1));
        chk("mr_outstanding_pre", 128'(outstanding), 128'(3));
        #2;
        rst = 1'b1;
        #1;
        chk("mr_valid", 128'(memctl_refill_valid), 128'(0));
        chk("mr_outstanding", 128'(outstanding), 128'(0));
        chk("mr_req_ready", 128'(miss_req_ready), 128'(0));
        chk("mr_id", 128'(memctl_refill_id), 128'(0));
        sb.delete();
        repeat (2) tick();
        rst = 1'b0;
        memctl_refill_ready = 1'b1;
        #1;
        chk("mr_release_ready", 128'(miss_req_ready), 128'(1));
        probe_latency(5'd13, line_data(5'd13));
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
